// File: rtl/jt51_mix_acc.sv
// rtl/jt51_mix_acc.sv - per-frame carrier mixer: accumulates 32 operator slots into saturated L/R samples
module jt51_mix_acc (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [13:0] op_in,
  input  logic               zero,
  input  logic [2:0]         con,
  input  logic [1:0]         rl,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               sample,
  output logic               clip
);

  logic [4:0]         cnt;
  logic [4:0]         slot;
  logic               seen;
  logic               carrier;
  logic signed [18:0] op_ext;
  logic signed [18:0] acc_l, acc_r;
  logic signed [18:0] sum_l, sum_r;
  logic signed [15:0] sat_l, sat_r;
  logic               clamp_l, clamp_r;

  // Upper two slot bits select M1/M2/C1/C2; which of them are carriers depends on con.
  always_comb begin
    slot = zero ? 5'd0 : cnt;
    case (slot[4:3])
      2'd0:    carrier = (con == 3'd7);
      2'd1:    carrier = (con >= 3'd5);
      2'd2:    carrier = (con >= 3'd4);
      default: carrier = 1'b1;
    endcase
    op_ext = {{5{op_in[13]}}, op_in};
    sum_l  = ((slot == 5'd0) ? 19'sd0 : acc_l) + ((carrier && rl[0]) ? op_ext : 19'sd0);
    sum_r  = ((slot == 5'd0) ? 19'sd0 : acc_r) + ((carrier && rl[1]) ? op_ext : 19'sd0);
  end

  always_comb begin
    clamp_l = 1'b1;
    clamp_r = 1'b1;
    if (sum_l > 19'sd32767)       sat_l = 16'sh7fff;
    else if (sum_l < -19'sd32768) sat_l = 16'sh8000;
    else begin
      sat_l   = sum_l[15:0];
      clamp_l = 1'b0;
    end
    if (sum_r > 19'sd32767)       sat_r = 16'sh7fff;
    else if (sum_r < -19'sd32768) sat_r = 16'sh8000;
    else begin
      sat_r   = sum_r[15:0];
      clamp_r = 1'b0;
    end
  end

  // seen gates output until a frame has started on a real zero marker since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 5'd0;
      seen   <= 1'b0;
      acc_l  <= 19'sd0;
      acc_r  <= 19'sd0;
      left   <= 16'sd0;
      right  <= 16'sd0;
      sample <= 1'b0;
      clip   <= 1'b0;
    end else begin
      cnt   <= slot + 5'd1;
      acc_l <= sum_l;
      acc_r <= sum_r;
      if (zero) seen <= 1'b1;
      if (slot == 5'd31 && seen) begin
        left   <= sat_l;
        right  <= sat_r;
        sample <= 1'b1;
        clip   <= clamp_l | clamp_r;
      end else begin
        sample <= 1'b0;
        clip   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jt51_mix_acc.md
JT51_MIX_ACC -- requirements
Module: jt51_mix_acc

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 SHALL have port op_in, input, signed 14 bits: the operator output sample for the current slot.
REQ-004 SHALL have port zero, input, 1 bit: high in the cycle whose op_in carries slot 0 of the 32-slot frame.
REQ-005 SHALL have port con, input, 3 bits: connection algorithm of the current slot's channel.
REQ-006 SHALL have port rl, input, 2 bits: pan enables of the current slot's channel; rl[1]=right, rl[0]=left.
REQ-007 SHALL have port left, output, signed 16 bits: saturated left sample.
REQ-008 SHALL have port right, output, signed 16 bits: saturated right sample.
REQ-009 SHALL have port sample, output, 1 bit: one-cycle strobe, high while left/right hold a freshly completed frame.
REQ-010 SHALL have port clip, output, 1 bit: high together with sample when either channel saturated in that frame.

Function
REQ-011 SHALL keep a 5-bit slot counter; current slot = 0 when zero=1, else counter; counter next = current slot + 1, wrapping 31->0.
REQ-012 SHALL decode the operator from the current slot: slot[4:3]=0 M1, 1 M2, 2 C1, 3 C2.
REQ-013 SHALL mark the current slot as a carrier per con: 0-3 -> C2 only; 4 -> C1, C2; 5-6 -> M2, C1, C2; 7 -> all four.
REQ-014 SHALL use a contribution equal to op_in sign-extended to 19 bits if the slot is a carrier, else 0, gated separately per side by rl.
REQ-015 SHALL keep two signed 19-bit accumulators (L, R); at slot 0, load the slot contribution (no add); at other slots, add it.
REQ-016 SHALL never overflow the accumulators (maximum 32 x |-8192| = 262144 fits in 19 bits signed).
REQ-017 SHALL, at the edge that processes slot 31 of a valid frame, register left/right = saturate16(acc + contribution), pulse sample for exactly one cycle, and set clip if either side clamped.
REQ-018 SHALL saturate to +32767 and -32768.
REQ-019 SHALL hold left, right and clip until the next frame completes; clip returns low when sample drops.
REQ-020 SHALL treat a frame as valid only if its slot 0 was marked by zero=1 and slots 1-31 followed consecutively.
REQ-021 SHALL, when zero arrives while the counter is not 0 (resync), discard the partial frame, load the accumulators from the new slot 0, and emit no strobe for the discarded frame.
REQ-022 SHALL, when the counter wraps 31->0 without zero, accept the frame as valid (zero is a marker, not mandatory each frame) once a first zero has been seen since reset.
REQ-023 SHALL have no latency other than the single register at slot 31; sample rises 1 cycle after the slot-31 input cycle.

Reset
REQ-024 SHALL, while rst=1, force left=0, right=0, sample=0, clip=0, both accumulators to 0, the counter to 0, and the seen-zero flag to 0, regardless of clk.
REQ-025 SHALL, after rst releases mid-frame, produce no sample until a full frame that starts with zero=1 completes.

Verification
REQ-026 SHALL be verified for a full frame: reset, then zero at slot 0, op_in=100, con=7, rl=11 for 32 slots -> left=right=3200, sample high 1 cycle, clip=0.
REQ-027 SHALL be verified for carrier gating: con=0, op_in=1000, rl=01 -> left=8000, right=0; and con=4, op_in=10, rl=11 -> left=right=160.
REQ-028 SHALL be verified for saturation: con=7, rl=11, op_in=8191 on all slots -> left=right=32767, clip=1; op_in=-8192 -> left=right=-32768, clip=1.
REQ-029 SHALL be verified for resync: zero asserted again at slot 10 -> no strobe, next strobe 32 cycles after the new zero, with a sum over only the new frame.
REQ-030 SHALL be verified for reset mid-frame: rst pulsed at slot 20 -> outputs 0 immediately, no strobe until 32 slots after the next zero.
REQ-031 SHALL be verified for the pre-zero condition: 64 cycles after reset with zero held low -> sample never asserts.
